// File: rtl/led_animator_multi.sv
// rtl/led_animator_multi.sv - multi-pattern LED bank animator (chase/bounce/fill/blink) with internal step prescaler
// Optional LED_ANIM_LOOP_EN: a run ending with active still high restarts back-to-back on the same edge.
module led_animator_multi #(
  parameter int N_LEDS    = 5,
  parameter int TICK_DIV  = 4,
  parameter int RUN_STEPS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] led,
  output logic              busy,
  output logic              done
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(RUN_STEPS + 1);
  localparam int PW = $clog2(N_LEDS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(RUN_STEPS - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(N_LEDS - 1);

  localparam logic [1:0] M_CHASE  = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_FILL   = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  localparam logic [N_LEDS-1:0] ONE  = 1;
  localparam logic [N_LEDS-1:0] ONES = '1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tick, tick_n;
  logic [SW-1:0]     step, step_n;
  logic [PW-1:0]     pos, pos_n, pos_adv;
  logic              dir, dir_n, dir_adv;
  logic [1:0]        mode_q, mode_n;
  logic              active_q;
  logic [N_LEDS-1:0] led_n;
  logic              busy_n, done_n;
  logic              rise, start;

  assign rise = active & ~active_q;

  // odd selects the dark phase of BLINK; bar for FILL is p+1 ones from bit0
  function automatic logic [N_LEDS-1:0] pattern(input logic [1:0] m,
                                                input logic [PW-1:0] p,
                                                input logic odd);
    case (m)
      M_BLINK: pattern = odd ? '0 : ONES;
      M_FILL:  pattern = ~(ONES << (p + PW'(1)));
      M_CHASE: pattern = ONE << p;
      default: pattern = ONE << p;
    endcase
  endfunction

  // Position after the current step; dir=1 means BOUNCE is travelling down
  always_comb begin
    pos_adv = pos;
    dir_adv = dir;
    if (mode_q == M_BOUNCE) begin
      if (!dir) begin
        if (pos == POS_LAST) begin
          pos_adv = pos - PW'(1);
          dir_adv = 1'b1;
        end else begin
          pos_adv = pos + PW'(1);
        end
      end else begin
        if (pos == '0) begin
          pos_adv = pos + PW'(1);
          dir_adv = 1'b0;
        end else begin
          pos_adv = pos - PW'(1);
        end
      end
    end else begin
      pos_adv = (pos == POS_LAST) ? '0 : pos + PW'(1);
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick;
    step_n  = step;
    pos_n   = pos;
    dir_n   = dir;
    mode_n  = mode_q;
    led_n   = led;
    busy_n  = busy;
    done_n  = 1'b0;
    start   = rise;

    if (!rise && state == S_RUN) begin
      if (tick != TICK_LAST) begin
        tick_n = tick + TW'(1);
      end else if (step != STEP_LAST) begin
        tick_n = '0;
        step_n = step + SW'(1);
        pos_n  = pos_adv;
        dir_n  = dir_adv;
        led_n  = pattern(mode_q, pos_adv, step_n[0]);
      end else begin
        state_n = S_IDLE;
        tick_n  = '0;
        step_n  = '0;
        pos_n   = '0;
        dir_n   = 1'b0;
        led_n   = '0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
`ifdef LED_ANIM_LOOP_EN
        start   = active;
`endif
      end
    end

    // A rise wins over run end; in loop mode it also covers the back-to-back restart
    if (start) begin
      state_n = S_RUN;
      tick_n  = '0;
      step_n  = '0;
      pos_n   = '0;
      dir_n   = 1'b0;
      mode_n  = mode;
      busy_n  = 1'b1;
      led_n   = pattern(mode, '0, 1'b0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tick     <= '0;
      step     <= '0;
      pos      <= '0;
      dir      <= 1'b0;
      mode_q   <= M_CHASE;
      active_q <= 1'b0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      tick     <= tick_n;
      step     <= step_n;
      pos      <= pos_n;
      dir      <= dir_n;
      mode_q   <= mode_n;
      active_q <= active;
      led      <= led_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
